// File: rtl/jt51_sh_tap.sv
// Reader tap on the time-multiplexed slot ring: captures the word of one
// requested slot from the delay-line output and hands it over with req/valid.
// Optional timeout when JT51_SH_TAP_TIMEOUT_EN is defined.
module jt51_sh_tap #(
  parameter int width  = 5,
  parameter int stages = 32,
  localparam int SW    = $clog2(stages)
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  input  logic [width-1:0] din,
  input  logic             zero,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic             rd_busy,
  output logic             rd_valid,
  output logic [width-1:0] rd_data,
  output logic             rd_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [SW-1:0] LAST = SW'(stages - 1);

  state_t           r_state, w_nxt;
  logic [SW-1:0]    r_cnt, r_slot_q, w_cur;
  logic             r_busy, r_valid;
  logic [width-1:0] r_data;
  logic             w_accept, w_capture, w_timeout, w_tmo_hit;

  // slot index of the word currently on din; zero forces a resync
  assign w_cur = zero            ? '0 :
                 (r_cnt == LAST) ? '0 : r_cnt + SW'(1);

  always_ff @(posedge clk or posedge rst)
    if (rst)      r_cnt <= LAST;
    else if (cen) r_cnt <= w_cur;

`ifdef JT51_SH_TAP_TIMEOUT_EN
  localparam logic [SW+1:0] TMO_LAST = (SW+2)'(2 * stages - 1);

  logic [SW+1:0] r_tmo;
  logic          r_err;

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst)                          r_tmo <= '0;
    else if (w_accept)                r_tmo <= '0;
    else if (r_state == WAIT && cen)  r_tmo <= r_tmo + (SW+2)'(1);

  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else     r_err <= w_timeout;

  assign rd_err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign rd_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;

  // capture is only evaluated in WAIT, so the accept cycle never matches
  always_comb begin
    w_nxt     = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: if (rd_req) begin
        w_accept = 1'b1;
        w_nxt    = WAIT;
      end
      WAIT: if (cen) begin
        if (w_cur == r_slot_q) begin
          w_capture = 1'b1;
          w_nxt     = DONE;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_nxt     = IDLE;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_slot_q <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_accept) begin
        r_slot_q <= rd_slot;
        r_busy   <= 1'b1;
      end else if (w_capture || w_timeout) begin
        r_busy   <= 1'b0;
      end
      if (w_capture) r_data <= din;
    end

  assign rd_busy  = r_busy;
  assign rd_valid = r_valid;
  assign rd_data  = r_data;

endmodule

// File: doc/jt51_sh_tap.md
Name: jt51_sh_tap

Overview:
- Reader end of the time-multiplexed slot ring: watches the serial output of a `width`-bit × `stages` delay line, one slot per `cen`.
- On a request, captures the value belonging to one chosen slot and hands it to a slower consumer (CPU status/readback path, debug port) with a req/valid handshake.
- Sits beside the delay line, fed by its output and the slot-0 sync pulse.

Parameters:
- width, 5, bits per slot word.
- stages, 32, slots per frame; must be ≥2.
- SW, $clog2(stages), slot index width (localparam).

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  single clock.
- cen  in  1  clock enable; one slot advances per cen cycle.
- din  in  width  current slot word (delay line output).
- zero  in  1  sampled only with cen; marks that din is slot 0.
- rd_req  in  1  single-clk read request pulse.
- rd_slot  in  SW  requested slot; sampled on accepted rd_req.
- rd_busy  out  1  request pending.
- rd_valid  out  1  one-clk pulse: rd_data updated.
- rd_data  out  width  captured slot word; held until next capture.
- rd_err  out  1  one-clk timeout pulse (see Optional Feature).

Behaviour:
- Reset values: rd_busy=0, rd_valid=0, rd_err=0, rd_data=0, state=IDLE, cnt=stages-1, slot_q=0, tmo=0.
- Slot tracking:
  - cur = 0 if zero, else (cnt==stages-1 ? 0 : cnt+1).
  - On a cen cycle: cnt <= cur.
  - Without any zero pulse, the first cen after reset is slot 0.
  - zero resynchronises immediately; no error is raised on a mid-frame zero.
- States IDLE, WAIT, DONE. State changes occur on clk edges independent of cen, except the capture condition below.
  - IDLE: rd_req=1 → slot_q <= rd_slot, tmo <= 0, rd_busy <= 1, go to WAIT. rd_req with rd_busy=1 is ignored (no queueing).
  - WAIT, capture: on a cen cycle with cur==slot_q → rd_data <= din, go to DONE.
    - The capture check is disabled on the cycle rd_req is accepted.
    - A request for the slot currently on din therefore waits one full frame (stages cen cycles).
  - WAIT, latency: worst case stages cen cycles after acceptance, plus 1 clk to rd_valid.
  - DONE: for exactly one clk, rd_valid=1 and rd_busy=0; then go to IDLE.
    - rd_req in DONE is ignored; a new request is accepted from IDLE only, earliest 2 clk after the capture edge.
- cen=0 for any number of clks: WAIT holds and cnt holds.
- rd_slot ≥ stages (non-power-of-2 stages only): the request never matches; recovery only via timeout or reset.
- Reset mid-operation: returns to IDLE immediately; a pending request is dropped with no rd_valid or rd_err.
- rd_data is never modified except on capture.

Optional Feature:
- Macro: JT51_SH_TAP_TIMEOUT_EN.
- Defined:
  - A counter tmo (SW+2 bits) increments on each cen cycle in WAIT.
  - If tmo reaches 2*stages with no capture, rd_err pulses 1 clk, rd_busy drops, state goes to IDLE, rd_data is unchanged.
  - A capture on the same cen as the limit takes priority: rd_valid is raised, no rd_err.
- Undefined: tmo logic is absent, rd_err is tied 0, and WAIT persists until capture or reset.

Test Plan:
1. Reset, then feed din=slot index (0..31) each cen, cen every 2nd clk; rd_req with rd_slot=7 at slot 3 → rd_valid 1 clk after cen of slot 7, rd_data=7, rd_busy high from req+1 until the capture edge.
2. rd_req rd_slot=12 on the clk where din=12 → capture skipped now; rd_data=12 exactly 32 cen later.
3. zero asserted while cnt=20, din=5'h1F; request slot 2 pending → capture uses the resynced count: two cen after zero, rd_data = din at that time.
4. Second rd_req (slot 4) while WAIT for slot 30 → ignored; only one rd_valid, rd_data=30.
5. rst pulse while WAIT → rd_busy=0, rd_valid never pulses, rd_data=0, cnt restarts (first cen → slot 0).
6. JT51_SH_TAP_TIMEOUT_EN, stages=24, rd_slot=27 → rd_err pulse after 48 cen, rd_data unchanged, rd_busy=0; without the macro → rd_busy stays 1 for 100 frames, rd_err=0.
